// File: rtl/riscv_pkg.sv
// Shared core definitions: decoder opcodes, arbiter state encodings and grant encoding
// for the unified memory port arbiter.
package riscv_pkg;

  localparam logic [6:0] lType = 7'b0000011;
  localparam logic [6:0] sType = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    IF_BUSY = 2'b01,
    D_BUSY  = 2'b10
  } arb_state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  // Data wins when it is the only requester, when data has fixed priority, or when
  // fetch held the previous grant under round-robin.
  function automatic logic grant_data(input logic want_if, input logic want_d,
                                      input logic data_first, input logic last_grant);
    return want_d & (~want_if | data_first | (last_grant == GNT_IF));
  endfunction

endpackage

// File: rtl/mem_wdog.sv
// Busy-state watchdog: counts busy cycles without ack and flags the cycle in which the
// access must be abandoned. Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_wdog
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_expire
);

  localparam int CW = (($clog2(TIMEOUT_CYCLES) + 1) > 5) ? ($clog2(TIMEOUT_CYCLES) + 1) : 5;

  logic [CW-1:0] r_wait_cnt;
  logic          w_at_limit;

  assign w_at_limit = (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign o_expire   = i_busy & ~i_ack & w_at_limit;

  // Held at zero outside busy states so every new access starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst || !i_busy || i_ack || w_at_limit) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store paths onto one single-ported memory with a
// req/ack handshake. Define MEM_TIMEOUT_EN to abort accesses that never receive an ack.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter bit DATA_FIRST     = 1'b1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic [31:0] ifRdata,
  output logic        ifValid,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  output logic [31:0] dRdata,
  output logic        dValid,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic        busErr,
  output logic        stall
);

  arb_state_t  r_state, w_state_nxt;
  logic        r_last_grant, w_last_grant_nxt;
  logic        r_mem_req, w_mem_req_nxt;
  logic        r_mem_we, w_mem_we_nxt;
  logic [31:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [31:0] r_if_rdata, w_if_rdata_nxt;
  logic [31:0] r_d_rdata, w_d_rdata_nxt;
  logic        r_if_valid, w_if_valid_nxt;
  logic        r_d_valid, w_d_valid_nxt;
  logic        r_bus_err, w_bus_err_nxt;
  logic        w_want_if, w_want_d, w_busy, w_expire;

  // A requester whose completion pulse is showing is still holding its old request.
  assign w_want_if = ifReq & ~r_if_valid;
  assign w_want_d  = dReq & ~r_d_valid;
  assign w_busy    = (r_state != IDLE);

`ifdef MEM_TIMEOUT_EN
  mem_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_busy   (w_busy),
    .i_ack    (memAck),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-register values; a timeout completes like an ack with zeroed data.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_if_rdata_nxt   = r_if_rdata;
    w_d_rdata_nxt    = r_d_rdata;
    w_if_valid_nxt   = 1'b0;
    w_d_valid_nxt    = 1'b0;
    w_bus_err_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (grant_data(w_want_if, w_want_d, DATA_FIRST, r_last_grant)) begin
          w_state_nxt     = D_BUSY;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = dWe;
          w_mem_addr_nxt  = dAddr;
          w_mem_wdata_nxt = dWdata;
        end else if (w_want_if) begin
          w_state_nxt    = IF_BUSY;
          w_mem_req_nxt  = 1'b1;
          w_mem_we_nxt   = 1'b0;
          w_mem_addr_nxt = ifAddr;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (memAck || w_expire) begin
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_bus_err_nxt = ~memAck;
          if (r_state == D_BUSY) begin
            w_last_grant_nxt = GNT_D;
            w_d_valid_nxt    = 1'b1;
            if (!r_mem_we) begin
              w_d_rdata_nxt = memAck ? memRdata : 32'h0000_0000;
            end else begin
              w_d_rdata_nxt = r_d_rdata;
            end
          end else begin
            w_last_grant_nxt = GNT_IF;
            w_if_valid_nxt   = 1'b1;
            w_if_rdata_nxt   = memAck ? memRdata : 32'h0000_0000;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_mem_req_nxt = 1'b0;
        w_mem_we_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath and handshake registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GNT_IF;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_wdata  <= 32'h0000_0000;
      r_if_rdata   <= 32'h0000_0000;
      r_d_rdata    <= 32'h0000_0000;
      r_if_valid   <= 1'b0;
      r_d_valid    <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_last_grant <= w_last_grant_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_if_rdata   <= w_if_rdata_nxt;
      r_d_rdata    <= w_d_rdata_nxt;
      r_if_valid   <= w_if_valid_nxt;
      r_d_valid    <= w_d_valid_nxt;
      r_bus_err    <= w_bus_err_nxt;
    end
  end

  assign memReq   = r_mem_req;
  assign memWe    = r_mem_we;
  assign memAddr  = r_mem_addr;
  assign memWdata = r_mem_wdata;
  assign ifRdata  = r_if_rdata;
  assign dRdata   = r_d_rdata;
  assign ifValid  = r_if_valid;
  assign dValid   = r_d_valid;
  assign busErr   = r_bus_err;
  assign stall    = ~rst & ((ifReq & ~r_if_valid) | (dReq & ~r_d_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (fixed priority and round-robin) share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ifReq, dReq, dWe, memAck, chk_en;
  logic [31:0] ifAddr, dAddr, dWdata, memRdata;

  logic [31:0] if_rdata_a[2], d_rdata_a[2], mem_addr_a[2], mem_wdata_a[2];
  logic        if_valid_a[2], d_valid_a[2], mem_req_a[2], mem_we_a[2], bus_err_a[2], stall_a[2];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.DATA_FIRST(1'b1), .TIMEOUT_CYCLES(TO)) u_dut_df (
    .clk(clk), .rst(rst), .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(if_rdata_a[0]),
    .ifValid(if_valid_a[0]), .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
    .dRdata(d_rdata_a[0]), .dValid(d_valid_a[0]), .memReq(mem_req_a[0]), .memWe(mem_we_a[0]),
    .memAddr(mem_addr_a[0]), .memWdata(mem_wdata_a[0]), .memRdata(memRdata), .memAck(memAck),
    .busErr(bus_err_a[0]), .stall(stall_a[0])
  );

  mem_port_arbiter #(.DATA_FIRST(1'b0), .TIMEOUT_CYCLES(TO)) u_dut_rr (
    .clk(clk), .rst(rst), .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(if_rdata_a[1]),
    .ifValid(if_valid_a[1]), .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
    .dRdata(d_rdata_a[1]), .dValid(d_valid_a[1]), .memReq(mem_req_a[1]), .memWe(mem_we_a[1]),
    .memAddr(mem_addr_a[1]), .memWdata(mem_wdata_a[1]), .memRdata(memRdata), .memAck(memAck),
    .busErr(bus_err_a[1]), .stall(stall_a[1])
  );

  // Transaction-level view: at most one access in flight, owned by fetch (0) or data (1).
  typedef struct {
    logic        busy;
    logic        who;
    logic        we;
    logic        last;
    logic        ifv;
    logic        dv;
    logic        berr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ifr;
    logic [31:0] dr;
    int          age;
  } mstate_t;

  mstate_t m[2];

  function automatic mstate_t step(input mstate_t s, input bit df);
    mstate_t n;
    bit wi, wd;
    n = s;
    n.ifv = 1'b0; n.dv = 1'b0; n.berr = 1'b0;
    wi = ifReq && !s.ifv;
    wd = dReq && !s.dv;
    if (rst) begin
      n.busy = 1'b0; n.who = 1'b0; n.we = 1'b0; n.last = 1'b0; n.age = 0;
      n.addr = 32'h0; n.wdata = 32'h0; n.ifr = 32'h0; n.dr = 32'h0;
    end else if (!s.busy) begin
      if (wd && (!wi || df || s.last == 1'b0)) begin
        n.busy = 1'b1; n.who = 1'b1; n.we = dWe; n.addr = dAddr; n.wdata = dWdata; n.age = 0;
      end else if (wi) begin
        n.busy = 1'b1; n.who = 1'b0; n.we = 1'b0; n.addr = ifAddr; n.age = 0;
      end
    end else if (memAck) begin
      n.busy = 1'b0; n.last = s.who;
      if (s.who) begin
        n.dv = 1'b1;
        if (!s.we) n.dr = memRdata;
      end else begin
        n.ifv = 1'b1; n.ifr = memRdata;
      end
    end
`ifdef MEM_TIMEOUT_EN
    else if (s.age == TO - 1) begin
      n.busy = 1'b0; n.last = s.who; n.berr = 1'b1;
      if (s.who) begin
        n.dv = 1'b1;
        if (!s.we) n.dr = 32'h0;
      end else begin
        n.ifv = 1'b1; n.ifr = 32'h0;
      end
    end
`endif
    else begin
      n.age = s.age + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m[0] <= step(m[0], 1'b1);
    m[1] <= step(m[1], 1'b0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("L%0d memReq", k), 32'(mem_req_a[k]), 32'(m[k].busy));
        chk($sformatf("L%0d memWe", k), 32'(mem_we_a[k]), 32'(m[k].busy & m[k].we));
        chk($sformatf("L%0d memAddr", k), mem_addr_a[k], m[k].addr);
        chk($sformatf("L%0d memWdata", k), mem_wdata_a[k], m[k].wdata);
        chk($sformatf("L%0d ifValid", k), 32'(if_valid_a[k]), 32'(m[k].ifv));
        chk($sformatf("L%0d dValid", k), 32'(d_valid_a[k]), 32'(m[k].dv));
        chk($sformatf("L%0d ifRdata", k), if_rdata_a[k], m[k].ifr);
        chk($sformatf("L%0d dRdata", k), d_rdata_a[k], m[k].dr);
        chk($sformatf("L%0d busErr", k), 32'(bus_err_a[k]), 32'(m[k].berr));
        chk($sformatf("L%0d stall", k), 32'(stall_a[k]),
            32'(!rst && ((ifReq && !m[k].ifv) || (dReq && !m[k].dv))));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b1; ifReq = 1'b0; ifAddr = 32'h0; dReq = 1'b0; dWe = 1'b0;
    dAddr = 32'h0; dWdata = 32'h0; memAck = 1'b0; memRdata = 32'h0; chk_en = 1'b0;
    tick(); tick();
    chk("reset memReq", 32'(mem_req_a[0]), 32'h0);
    chk("reset ifRdata", if_rdata_a[0], 32'h0);
    chk("reset dRdata", d_rdata_a[1], 32'h0);
    chk("reset stall", 32'(stall_a[0]), 32'h0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Fetch with ack on the third cycle after memReq rises.
    ifReq = 1'b1; ifAddr = 32'h0000_0004;
    tick();
    chk("fetch memReq", 32'(mem_req_a[0]), 32'h1);
    chk("fetch memAddr", mem_addr_a[0], 32'h0000_0004);
    chk("fetch stall", 32'(stall_a[0]), 32'h1);
    tick(); tick();
    memAck = 1'b1; memRdata = 32'h0051_0113;
    tick();
    chk("fetch ifValid", 32'(if_valid_a[0]), 32'h1);
    chk("fetch ifRdata", if_rdata_a[0], 32'h0051_0113);
    chk("fetch stall low", 32'(stall_a[0]), 32'h0);
    memAck = 1'b0; ifReq = 1'b0;
    tick();
    chk("no regrant memReq", 32'(mem_req_a[0]), 32'h0);

    // Store with requester inputs changing while busy.
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h0000_0100; dWdata = 32'hDEAD_BEEF;
    tick();
    chk("store memWe", 32'(mem_we_a[0]), 32'h1);
    dWdata = 32'h1234_5678; dAddr = 32'h0000_0FFC;
    memAck = 1'b1; memRdata = 32'hCAFE_F00D;
    tick();
    chk("store memWdata held", mem_wdata_a[0], 32'hDEAD_BEEF);
    chk("store dValid", 32'(d_valid_a[0]), 32'h1);
    chk("store dRdata kept", d_rdata_a[0], 32'h0);
    memAck = 1'b0; dReq = 1'b0; dWe = 1'b0;
    tick();

    // Simultaneous requests: fixed priority takes data, round-robin (last = data) takes fetch.
    ifReq = 1'b1; ifAddr = 32'h0000_0040; dReq = 1'b1; dAddr = 32'h0000_0200;
    tick();
    chk("df grants data", mem_addr_a[0], 32'h0000_0200);
    chk("rr grants fetch", mem_addr_a[1], 32'h0000_0040);
    memAck = 1'b1; memRdata = 32'h0BAD_F00D;
    tick();
    chk("df load dRdata", d_rdata_a[0], 32'h0BAD_F00D);
    chk("df idle gap", 32'(mem_req_a[0]), 32'h0);
    memAck = 1'b0; dReq = 1'b0;
    tick();
    chk("df fetch second", mem_addr_a[0], 32'h0000_0040);
    memAck = 1'b1; memRdata = 32'h0000_0013;
    tick();
    chk("df fetch done", 32'(if_valid_a[0]), 32'h1);
    memAck = 1'b0; ifReq = 1'b0;
    tick(); tick(); tick();

    // Stray ack while idle.
    memAck = 1'b1; memRdata = 32'hFFFF_FFFF;
    tick();
    chk("idle ack dValid", 32'(d_valid_a[0]), 32'h0);
    chk("idle ack ifValid", 32'(if_valid_a[0]), 32'h0);
    memAck = 1'b0;
    tick();

    // Reset during the second busy cycle of a load.
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h0000_0300;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst forces stall 0", 32'(stall_a[0]), 32'h0);
    tick();
    chk("rst drops memReq", 32'(mem_req_a[0]), 32'h0);
    chk("rst no dValid", 32'(d_valid_a[0]), 32'h0);
    rst = 1'b0; dReq = 1'b0;
    ifReq = 1'b1; ifAddr = 32'h0000_0008;
    tick();
    memAck = 1'b1; memRdata = 32'h0000_0067;
    tick();
    chk("post-rst fetch", if_rdata_a[0], 32'h0000_0067);
    memAck = 1'b0; ifReq = 1'b0;
    tick();

    // Load that never gets an ack.
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h0000_0400;
    tick();
    n = 0; seen = 1'b0;
    for (int i = 1; i <= 110 && !seen; i++) begin
      tick();
      if (d_valid_a[0]) begin
        seen = 1'b1; n = i;
      end
    end
`ifdef MEM_TIMEOUT_EN
    chk("timeout latency", 32'(n), 32'(TO));
    chk("timeout dRdata", d_rdata_a[0], 32'h0);
    dReq = 1'b0;
    tick();
`else
    chk("no timeout valid", 32'(seen), 32'h0);
    chk("no timeout memReq", 32'(mem_req_a[0]), 32'h1);
    chk("no timeout busErr", 32'(bus_err_a[0]), 32'h0);
    memAck = 1'b1; memRdata = 32'h0000_1111;
    tick();
    chk("late ack dValid", 32'(d_valid_a[0]), 32'h1);
    memAck = 1'b0; dReq = 1'b0;
    tick();
`endif

    // Random traffic; requests are held until lane 0 reports completion.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (ifReq && if_valid_a[0]) ifReq = ($urandom_range(0, 3) == 0);
      else if (!ifReq) ifReq = ($urandom_range(0, 2) == 0);
      if (dReq && d_valid_a[0]) dReq = ($urandom_range(0, 3) == 0);
      else if (!dReq) begin
        dReq = ($urandom_range(0, 2) == 0);
        dWe = 1'($urandom_range(0, 1));
      end
      ifAddr = $urandom; dAddr = $urandom; dWdata = $urandom; memRdata = $urandom;
      memAck = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0; ifReq = 1'b0; dReq = 1'b0; memAck = 1'b0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
